// File: rtl/request_conditioner.sv
// Conditions raw pedestrian-button and emergency-sensor inputs for a traffic-light
// controller: synchronise, debounce, sequence pedestrian requests, and police emergency requests.
module request_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int PED_COOLDOWN    = 10,
   parameter int EMG_HOLD        = 8,
   parameter int EMG_TIMEOUT     = 200
) (
   input  logic clk,
   input  logic reset,
   input  logic ped_button,
   input  logic emg_sensor,
   input  logic ped_green,
   output logic pedestrian_req,
   output logic emergency,
   output logic ped_wait,
   output logic emg_fault
);

   localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0] COOL_LOAD = 8'(PED_COOLDOWN);
   localparam logic [7:0] HOLD_LOAD = 8'(EMG_HOLD);
   localparam logic [7:0] TO_LAST   = 8'(EMG_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, PENDING, SERVING, COOLDOWN} ped_state_t;

   logic [1:0] raw_in;
   logic [1:0] db_val;

   assign raw_in = {emg_sensor, ped_button};

   // Bit 0 is the pedestrian button, bit 1 the emergency sensor.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_deb
         logic       s1_reg;
         logic       s2_reg;
         logic       db_reg;
         logic [7:0] cnt_reg;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               s1_reg  <= 1'b0;
               s2_reg  <= 1'b0;
               db_reg  <= 1'b0;
               cnt_reg <= '0;
            end else begin
               s1_reg <= raw_in[gi];
               s2_reg <= s1_reg;
               if (s2_reg != db_reg) begin
                  if (cnt_reg == DB_LAST) begin
                     db_reg  <= s2_reg;
                     cnt_reg <= '0;
                  end else if (cnt_reg != 8'hFF) begin
                     cnt_reg <= cnt_reg + 8'd1;
                  end
               end else begin
                  cnt_reg <= '0;
               end
            end
         end

         assign db_val[gi] = db_reg;
      end
   endgenerate

   // ---------------- pedestrian path ----------------
   ped_state_t state_reg, state_next;
   logic [7:0] cool_cnt_reg, cool_cnt_next;
   logic       latch_reg, latch_next;
   logic       ped_db_prev_reg;
   logic       ped_rise;

   assign ped_rise = db_val[0] & ~ped_db_prev_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         cool_cnt_reg    <= '0;
         latch_reg       <= 1'b0;
         ped_db_prev_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cool_cnt_reg    <= cool_cnt_next;
         latch_reg       <= latch_next;
         ped_db_prev_reg <= db_val[0];
      end
   end

   always_comb begin
      state_next    = state_reg;
      cool_cnt_next = cool_cnt_reg;
      latch_next    = latch_reg;
      case (state_reg)
         IDLE: begin
            if (ped_rise) state_next = PENDING;
         end
         PENDING: begin
            if (ped_green) state_next = SERVING;
         end
         SERVING: begin
            if (!ped_green) begin
               state_next    = COOLDOWN;
               cool_cnt_next = COOL_LOAD;
            end
         end
         COOLDOWN: begin
            if (ped_rise) latch_next = 1'b1;
            // A press landing on the final cooldown cycle still counts.
            if (cool_cnt_reg <= 8'd1) begin
               state_next    = (latch_reg || ped_rise) ? PENDING : IDLE;
               latch_next    = 1'b0;
               cool_cnt_next = '0;
            end else begin
               cool_cnt_next = cool_cnt_reg - 8'd1;
            end
         end
         default: begin
            state_next    = IDLE;
            cool_cnt_next = '0;
            latch_next    = 1'b0;
         end
      endcase
   end

   assign pedestrian_req = (state_reg == PENDING);
   assign ped_wait       = (state_reg == PENDING) || ((state_reg == COOLDOWN) && latch_reg);

   // ---------------- emergency path ----------------
   logic       emergency_reg;
   logic       emg_fault_reg;
   logic [7:0] hold_cnt_reg;
   logic [7:0] to_cnt_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         emergency_reg <= 1'b0;
         emg_fault_reg <= 1'b0;
         hold_cnt_reg  <= '0;
         to_cnt_reg    <= '0;
      end else if (emg_fault_reg) begin
         emergency_reg <= 1'b0;
         to_cnt_reg    <= '0;
         if (!db_val[1]) emg_fault_reg <= 1'b0;
      end else if (emergency_reg && (to_cnt_reg == TO_LAST)) begin
         emergency_reg <= 1'b0;
         emg_fault_reg <= 1'b1;
         to_cnt_reg    <= '0;
      end else begin
         if (emergency_reg) begin
            if (to_cnt_reg != 8'hFF) to_cnt_reg <= to_cnt_reg + 8'd1;
         end else begin
            to_cnt_reg <= '0;
         end
         // Sensor high (re)arms the hold; once it drops, the hold runs down.
         if (db_val[1]) begin
            emergency_reg <= 1'b1;
            hold_cnt_reg  <= HOLD_LOAD;
         end else if (emergency_reg) begin
            if (hold_cnt_reg == 8'd0) emergency_reg <= 1'b0;
            else                      hold_cnt_reg  <= hold_cnt_reg - 8'd1;
         end
      end
   end

   assign emergency = emergency_reg;
   assign emg_fault = emg_fault_reg;

endmodule

// File: tb/tb_request_conditioner.sv
// Directed and randomised checks of request_conditioner against an event-level model
// that tracks edge numbers for cooldown end, hold expiry and timeout.
module tb_request_conditioner;

   localparam int D  = 4;
   localparam int PC = 10;
   localparam int H  = 8;
   localparam int T  = 200;

   logic clk = 1'b0;
   logic reset;
   logic ped_button, emg_sensor, ped_green;
   logic pedestrian_req, emergency, ped_wait, emg_fault;

   request_conditioner #(
      .DEBOUNCE_CYCLES(D), .PED_COOLDOWN(PC), .EMG_HOLD(H), .EMG_TIMEOUT(T)
   ) dut (
      .clk(clk), .reset(reset), .ped_button(ped_button), .emg_sensor(emg_sensor),
      .ped_green(ped_green), .pedestrian_req(pedestrian_req), .emergency(emergency),
      .ped_wait(ped_wait), .emg_fault(emg_fault)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int n     = 0;

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_WAITING, M_WALK, M_COOL} walk_t;
   walk_t      m_walk;
   bit [D+1:0] ped_hist, emg_hist;   // bit k = raw input sampled k edges ago
   bit         m_db_ped, m_db_emg, m_ped_rose, m_latch, m_emg, m_fault;
   int         cool_end, last_e, rise_edge;

   task automatic model_reset();
      m_walk = M_IDLE;
      ped_hist = '0; emg_hist = '0;
      m_db_ped = 0; m_db_emg = 0; m_ped_rose = 0; m_latch = 0;
      m_emg = 0; m_fault = 0; cool_end = 0; last_e = 0; rise_edge = 0;
   endtask

   // A debounced value flips once the synchronised stream (raw delayed 2 edges)
   // has disagreed with it for D consecutive edges.
   function automatic bit settles(bit [D+1:0] h, bit cur);
      bit [D-1:0] win;
      win = h[D+1:2];
      return win == {D{~cur}};
   endfunction

   task automatic model_edge(bit p, bit e, bit g);
      bit e_seen, rise_seen, new_db;
      n++;
      e_seen    = m_db_emg;
      rise_seen = m_ped_rose;
      ped_hist  = {ped_hist[D:0], p};
      emg_hist  = {emg_hist[D:0], e};
      new_db     = settles(ped_hist, m_db_ped) ? !m_db_ped : m_db_ped;
      m_ped_rose = new_db && !m_db_ped;
      m_db_ped   = new_db;
      if (settles(emg_hist, m_db_emg)) m_db_emg = !m_db_emg;

      case (m_walk)
         M_IDLE:    if (rise_seen) m_walk = M_WAITING;
         M_WAITING: if (g) m_walk = M_WALK;
         M_WALK:    if (!g) begin m_walk = M_COOL; cool_end = n + PC; end
         M_COOL: begin
            if (rise_seen) m_latch = 1;
            if (n == cool_end) begin
               m_walk  = m_latch ? M_WAITING : M_IDLE;
               m_latch = 0;
            end
         end
      endcase

      if (m_fault) begin
         m_emg = 0;
         if (!e_seen) m_fault = 0;
      end else if (m_emg && (n - rise_edge == T)) begin
         m_emg = 0;
         m_fault = 1;
      end else if (e_seen) begin
         if (!m_emg) rise_edge = n;
         m_emg  = 1;
         last_e = n;
      end else if (m_emg && (n > last_e + H)) begin
         m_emg = 0;
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(string tag, logic obs, logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b edge=%0d", tag, obs, exp, n);
      end
   endtask

   task automatic chk_int(string tag, int obs, int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d edge=%0d", tag, obs, exp, n);
      end
   endtask

   task automatic check_model();
      chk("pedestrian_req", pedestrian_req, m_walk == M_WAITING);
      chk("ped_wait", ped_wait, (m_walk == M_WAITING) || (m_walk == M_COOL && m_latch));
      chk("emergency", emergency, m_emg);
      chk("emg_fault", emg_fault, m_fault);
   endtask

   task automatic check_zero(string tag);
      chk({tag, "_req"}, pedestrian_req, 1'b0);
      chk({tag, "_wait"}, ped_wait, 1'b0);
      chk({tag, "_emg"}, emergency, 1'b0);
      chk({tag, "_fault"}, emg_fault, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_edge(ped_button, emg_sensor, ped_green);
      check_model();
   endtask

   task automatic settle(int cycles);
      ped_button = 0; emg_sensor = 0; ped_green = 0;
      repeat (cycles) tick();
   endtask

   int first_req, first_wait, first_emg, cnt, t;
   bit seen, wait_early;
   int pb_left, es_left, pg_left;

   initial begin
      reset = 1; ped_button = 0; emg_sensor = 0; ped_green = 0;
      model_reset();
      #2;
      check_zero("reset0");
      repeat (2) begin @(posedge clk); #1; check_zero("reset_hold"); end
      reset = 0;
      settle(5);

      // Clean press: request and wait lamp appear D+3 edges after the press.
      ped_button = 1; first_req = 0; first_wait = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (pedestrian_req && first_req == 0) first_req = k;
         if (ped_wait && first_wait == 0) first_wait = k;
      end
      chk_int("req_latency", first_req, D + 3);
      chk_int("wait_latency", first_wait, D + 3);
      ped_button = 0; ped_green = 1;
      tick();
      chk("req_drop_on_green", pedestrian_req, 1'b0);
      repeat (5) tick();
      ped_green = 0;
      cnt = 0;
      for (int k = 0; k < PC + 5; k++) begin
         tick();
         if (dut.state_reg != 2'd0) cnt++;
      end
      chk_int("cooldown_len", cnt, PC);
      settle(5);

      // Bounce: toggling every 2 cycles never survives the debouncer.
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         ped_button = ((k / 2) % 2 == 0);
         tick();
         if (pedestrian_req) seen = 1;
      end
      ped_button = 0;
      repeat (15) begin tick(); if (pedestrian_req) seen = 1; end
      chk("bounce_no_req", seen, 1'b0);

      // Press during cooldown: latched, then served when cooldown expires.
      ped_button = 1;
      repeat (8) tick();
      ped_button = 0; ped_green = 1;
      repeat (6) tick();
      ped_green = 0;
      first_req = 0; wait_early = 0;
      for (t = 1; t <= 25; t++) begin
         tick();
         if (t == 3) ped_button = 1;
         if (t == 11) ped_button = 0;
         if (ped_wait && !pedestrian_req) wait_early = 1;
         if (pedestrian_req && first_req == 0) first_req = t;
      end
      chk("latch_wait", wait_early, 1'b1);
      chk_int("relatch_req_edge", first_req, PC + 1);
      ped_green = 1;
      repeat (3) tick();
      ped_green = 0;
      settle(PC + 5);

      // Emergency with hold.
      emg_sensor = 1; first_emg = 0; cnt = 0;
      for (int k = 1; k <= 50; k++) begin
         if (k == 21) emg_sensor = 0;
         tick();
         if (emergency) begin cnt++; if (first_emg == 0) first_emg = k; end
      end
      chk_int("emg_latency", first_emg, D + 3);
      chk_int("emg_high_cycles", cnt, 20 + H);
      settle(5);

      // Stuck sensor: timeout, fault, recovery.
      emg_sensor = 1; cnt = 0;
      repeat (300) begin tick(); if (emergency) cnt++; end
      chk_int("timeout_cycles", cnt, T);
      chk("fault_set", emg_fault, 1'b1);
      emg_sensor = 0;
      repeat (20) tick();
      chk("fault_cleared", emg_fault, 1'b0);
      emg_sensor = 1; cnt = 0;
      repeat (15) begin tick(); if (emergency) cnt++; end
      chk_int("emg_after_fault", cnt, 15 - (D + 3) + 1);
      settle(25);

      // Reset mid-PENDING with emergency active.
      ped_button = 1; emg_sensor = 1;
      repeat (10) tick();
      chk("pre_reset_req", pedestrian_req, 1'b1);
      chk("pre_reset_emg", emergency, 1'b1);
      #3;
      reset = 1;
      #1;
      check_zero("async_reset");
      model_reset();
      ped_button = 0; emg_sensor = 0; ped_green = 0;
      repeat (3) begin @(posedge clk); #1; check_zero("in_reset"); end
      reset = 0;
      repeat (20) begin tick(); end
      check_zero("post_reset");

      // Randomised run: independent bursts on all three inputs.
      pb_left = 0; es_left = 0; pg_left = 0;
      for (int k = 0; k < 1500; k++) begin
         if (pb_left == 0) begin ped_button = ~ped_button; pb_left = $urandom_range(1, 12); end
         if (es_left == 0) begin emg_sensor = ~emg_sensor; es_left = $urandom_range(1, 30); end
         if (pg_left == 0) begin ped_green  = ~ped_green;  pg_left = $urandom_range(1, 15); end
         pb_left--; es_left--; pg_left--;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
